// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and the write-back queue entry type
package regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NUM_REGS = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular write-back queue, two write lanes (lane 0 older), one read lane
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  push0,
    input  logic                                  push1,
    input  wb_entry_t                             din0,
    input  wb_entry_t                             din1,
    input  logic                                  pop,
    output wb_entry_t                             head,
    output logic [$clog2(DEPTH):0]                count,
    output logic [DEPTH-1:0]                      ent_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]      ent_rd
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    wb_entry_t mem [DEPTH];
    logic [AW-1:0] wptr, rptr, wptr1;
    // lane 1 lands behind lane 0 only when lane 0 also writes
    assign wptr1 = wptr + AW'(push0);
    assign head = mem[rptr];
    always_ff @(posedge clk) begin
        if (push0) mem[wptr] <= din0;
        if (push1) mem[wptr1] <= din1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(push0) + AW'(push1);
            rptr  <= rptr + AW'(pop);
            count <= count + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [AW-1:0] off;
        assign off = AW'(i) - rptr;
        assign ent_valid[i] = {1'b0, off} < count;
        assign ent_rd[i] = mem[i].rd;
    end
endmodule

// File: rtl/regfile_writer.sv
// regfile_writer: merges ALU and load results into an in-order queue and
// retires one register-file write per clock, publishing a pending mask.
module regfile_writer
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [REG_ADDR_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0]       alu_data,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [REG_ADDR_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0]       mem_data,
    output logic [REG_ADDR_W-1:0]   Write_register,
    output logic [DATA_W-1:0]       Write_data,
    output logic                    RegWrite,
    output logic [NUM_REGS-1:0]     pending,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [CW-1:0] free;
    logic mem_acc, alu_acc, pop;
    wb_entry_t din0, din1, head;
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
    // ALU needs two free slots so a simultaneous load always fits in front of it
    assign free = CW'(DEPTH) - count;
    assign mem_ready = free != '0;
    assign alu_ready = free > CW'(1);
    assign mem_acc = mem_valid && mem_ready && mem_rd != ZERO_REG;
    assign alu_acc = alu_valid && alu_ready && alu_rd != ZERO_REG;
    assign din0 = mem_acc ? wb_entry_t'{rd: mem_rd, data: mem_data} : wb_entry_t'{rd: alu_rd, data: alu_data};
    assign din1 = wb_entry_t'{rd: alu_rd, data: alu_data};
    assign pop = count != '0;
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push0    (mem_acc | alu_acc),
        .push1    (mem_acc & alu_acc),
        .din0     (din0),
        .din1     (din1),
        .pop      (pop),
        .head     (head),
        .count    (count),
        .ent_valid(ent_valid),
        .ent_rd   (ent_rd)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWrite       <= 1'b0;
            Write_register <= '0;
            Write_data     <= '0;
        end else begin
            RegWrite <= pop;
            if (pop) begin
                Write_register <= head.rd;
                Write_data     <= head.data;
            end
        end
    end
    always_comb begin
        pending = '0;
        if (RegWrite) pending[Write_register] = 1'b1;
        for (int k = 0; k < DEPTH; k++)
            if (ent_valid[k]) pending[ent_rd[k]] = 1'b1;
        pending[0] = 1'b0;
    end
endmodule

// File: tb/tb_regfile_writer.sv
// tb_regfile_writer: scoreboard bench for regfile_writer (DEPTH = 4)
module tb_regfile_writer;
    import regfile_pkg::*;
    localparam int DEPTH = 4;
    logic clk = 0, rst = 1;
    logic alu_valid = 0, mem_valid = 0;
    logic alu_ready, mem_ready, RegWrite;
    logic [4:0] alu_rd = 0, mem_rd = 0, Write_register;
    logic [31:0] alu_data = 0, mem_data = 0, Write_data, pending;
    logic [2:0] count;
    regfile_writer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .Write_register(Write_register), .Write_data(Write_data), .RegWrite(RegWrite),
        .pending(pending), .count(count)
    );
    always #5 clk = ~clk;
    wb_entry_t sb[$];
    logic exp_rw = 0;
    logic [4:0] exp_wr = 0;
    logic [31:0] exp_wd = 0;
    logic [31:0] rf [32];
    int n_chk = 0, n_pass = 0;
    bit last_macc, last_aacc;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    function automatic logic [31:0] exp_pending();
        logic [31:0] p;
        p = '0;
        if (exp_rw) p[exp_wr] = 1'b1;
        foreach (sb[i]) p[sb[i].rd] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction
    // one clock: drive inputs, predict acceptance, then check everything after the edge
    task automatic step(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic av, input logic [4:0] ard, input logic [31:0] ad);
        bit macc, aacc;
        wb_entry_t e;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        check("mem_ready", mem_ready, sb.size() < DEPTH);
        check("alu_ready", alu_ready, sb.size() <= DEPTH - 2);
        macc = mv && sb.size() < DEPTH;
        aacc = av && sb.size() <= DEPTH - 2;
        last_macc = macc;
        last_aacc = aacc;
        @(posedge clk);
        #1;
        exp_rw = sb.size() != 0;
        if (exp_rw) begin
            e = sb.pop_front();
            exp_wr = e.rd;
            exp_wd = e.data;
        end
        if (macc && mrd != 0) sb.push_back('{rd: mrd, data: md});
        if (aacc && ard != 0) sb.push_back('{rd: ard, data: ad});
        check("RegWrite", RegWrite, exp_rw);
        check("Write_register", Write_register, exp_wr);
        check("Write_data", Write_data, exp_wd);
        check("count", count, sb.size());
        check("pending", pending, exp_pending());
        if (RegWrite) rf[Write_register] = Write_data;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask
    initial begin
        int nxt;
        foreach (rf[i]) rf[i] = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("reset RegWrite", RegWrite, 0);
        check("reset count", count, 0);
        check("reset pending", pending, 0);
        check("reset mem_ready", mem_ready, 1);
        check("reset alu_ready", alu_ready, 1);
        // single ALU write
        step(0, 0, 0, 1, 3, 32'h11AB0);
        check("single pending3 N", pending[3], 1);
        step(0, 0, 0, 0, 0, 0);
        check("single write", {RegWrite, Write_register, Write_data}, {1'b1, 5'd3, 32'h11AB0});
        check("single pending3 N+1", pending[3], 1);
        step(0, 0, 0, 0, 0, 0);
        check("single pending3 N+2", pending[3], 0);
        idle(1);
        // dual accept, same rd: load first, ALU wins
        step(1, 4, 32'h2B124E, 1, 4, 32'h35A4);
        idle(4);
        check("dual final r4", rf[4], 32'h35A4);
        // zero register discarded
        step(1, 0, 32'hFFFFFFFF, 0, 0, 0);
        step(1, 0, 32'hFFFFFFFF, 1, 0, 32'h1234);
        idle(2);
        // back-pressure with distinct rd 1..8
        nxt = 1;
        for (int c = 0; c < 40 && nxt <= 8; c++) begin
            step(1, 5'(nxt), 32'h100 * nxt, nxt < 8, 5'(nxt + 1), 32'h100 * (nxt + 1));
            nxt += int'(last_macc) + int'(last_aacc && nxt < 8);
        end
        check("bp all accepted", nxt, 9);
        idle(6);
        for (int r = 1; r <= 8; r++) check("bp rf", rf[r], 32'h100 * r);
        // asynchronous reset mid-burst
        step(1, 9, 32'h9, 1, 10, 32'hA);
        step(1, 11, 32'hB, 1, 12, 32'hC);
        step(1, 13, 32'hD, 0, 0, 0);
        mem_valid = 0; alu_valid = 0;
        #3 rst = 1;
        #1;
        check("async RegWrite", RegWrite, 0);
        check("async count", count, 0);
        check("async pending", pending, 0);
        check("async mem_ready", mem_ready, 1);
        check("async alu_ready", alu_ready, 1);
        sb.delete();
        exp_rw = 0; exp_wr = 0; exp_wd = 0;
        @(posedge clk);
        #1 rst = 0;
        idle(5);
        // random traffic, including rd = 0
        for (int c = 0; c < 300; c++)
            step($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom);
        idle(6);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
